// File: rtl/pll_lock_supervisor.sv
// Purpose     : sequences PLL reset, waits for and qualifies lock, releases the downstream reset,
//               and supervises lock while running; repeated failed lock attempts latch FAILED.
// Latency     : every output is registered and changes on the same edge as the state register.
//               locked_in reaches the FSM through a 2-flop synchronizer (2 refclk cycles).
// Backpressure: none; free-running control block with no handshakes.
//
// Ports
//   refclk        sole clock, rising edge
//   rst           synchronous active-high reset
//   locked_in     PLL lock indication, asynchronous to refclk
//   pll_rst       reset to the PLL (active high)
//   sys_rst       reset to downstream clock domains (active high, low only in RUN)
//   lock_lost     one-cycle pulse when lock is lost in RUN
//   relock_count  lock losses seen in RUN, saturates at 255
//   fail          high while in FAILED (left only through rst)
//
// Build option: define PLL_SUP_GLITCH_FILTER_EN to require 4 consecutive unlocked cycles in RUN
// before a lock loss is declared; by default a single unlocked cycle is a lock loss.
module pll_lock_supervisor #(
   parameter int RST_PULSE_CYCLES    = 12,
   parameter int LOCK_TIMEOUT_CYCLES = 12000,
   parameter int STABLE_CYCLES       = 1200,
   parameter int MAX_RETRIES         = 4
) (
   input  logic       refclk,
   input  logic       rst,
   input  logic       locked_in,
   output logic       pll_rst,
   output logic       sys_rst,
   output logic       lock_lost,
   output logic [7:0] relock_count,
   output logic       fail
);

   localparam int CNT_MAX =
      (RST_PULSE_CYCLES > LOCK_TIMEOUT_CYCLES)
         ? ((RST_PULSE_CYCLES > STABLE_CYCLES) ? RST_PULSE_CYCLES : STABLE_CYCLES)
         : ((LOCK_TIMEOUT_CYCLES > STABLE_CYCLES) ? LOCK_TIMEOUT_CYCLES : STABLE_CYCLES);
   // At least 2 bits: the counter also measures the unlocked run length in RUN.
   localparam int CNT_W   = (CNT_MAX < 3) ? 2 : $clog2(CNT_MAX + 1);
   localparam int RETRY_W = (MAX_RETRIES < 2) ? 1 : $clog2(MAX_RETRIES + 1);

   localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(RST_PULSE_CYCLES - 1);
   localparam logic [CNT_W-1:0]   LOCK_LAST   = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
   localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [RETRY_W-1:0] RETRY_LAST  = RETRY_W'(MAX_RETRIES - 1);
`ifdef PLL_SUP_GLITCH_FILTER_EN
   localparam logic [CNT_W-1:0]   GLITCH_LAST = CNT_W'(3);
`endif

   typedef enum logic [2:0] {
      S_PLL_RESET   = 3'd0,
      S_WAIT_LOCK   = 3'd1,
      S_STABLE_WAIT = 3'd2,
      S_RUN         = 3'd3,
      S_FAILED      = 3'd4
   } state_t;

   state_t             state;
   state_t             state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [RETRY_W-1:0] retry;
   logic [1:0]         sync_q;
   logic               locked_s;
   logic               retry_inc;
   logic               lost_det;

   assign locked_s = sync_q[1];

   // Next-state decode; the registered block below owns all state and outputs.
   always_comb begin
      state_nxt = state;
      retry_inc = 1'b0;
      lost_det  = 1'b0;
      case (state)
         S_PLL_RESET: begin
            if (cnt == RST_LAST) state_nxt = S_WAIT_LOCK;
         end
         S_WAIT_LOCK: begin
            if (locked_s) begin
               state_nxt = S_STABLE_WAIT;
            end else if (cnt == LOCK_LAST) begin
               retry_inc = 1'b1;
               state_nxt = (retry == RETRY_LAST) ? S_FAILED : S_PLL_RESET;
            end
         end
         S_STABLE_WAIT: begin
            if (!locked_s)                state_nxt = S_WAIT_LOCK;
            else if (cnt == STABLE_LAST)  state_nxt = S_RUN;
         end
         S_RUN: begin
`ifdef PLL_SUP_GLITCH_FILTER_EN
            lost_det = !locked_s && (cnt == GLITCH_LAST);
`else
            lost_det = !locked_s;
`endif
            if (lost_det) state_nxt = S_PLL_RESET;
         end
         S_FAILED: begin
            state_nxt = S_FAILED;
         end
         default: begin
            state_nxt = S_PLL_RESET;
         end
      endcase
   end

   always_ff @(posedge refclk) begin
      if (rst) begin
         sync_q       <= 2'b00;
         state        <= S_PLL_RESET;
         cnt          <= '0;
         retry        <= '0;
         pll_rst      <= 1'b1;
         sys_rst      <= 1'b1;
         lock_lost    <= 1'b0;
         relock_count <= 8'd0;
         fail         <= 1'b0;
      end else begin
         // Held clear while the PLL is in reset so a lock level left over from
         // before the reset pulse can never qualify the new lock attempt.
         sync_q <= pll_rst ? 2'b00 : {sync_q[0], locked_in};

         state <= state_nxt;

         if (state_nxt != state)  cnt <= '0;
         else if (state == S_RUN) cnt <= locked_s ? '0 : cnt + CNT_W'(1); // unlocked run length
         else if (state != S_FAILED) cnt <= cnt + CNT_W'(1);

         if (state == S_STABLE_WAIT && state_nxt == S_RUN) retry <= '0;
         else if (retry_inc)                                retry <= retry + RETRY_W'(1);

         lock_lost <= lost_det;
         if (lost_det && relock_count != 8'hFF) relock_count <= relock_count + 8'd1;

         // Outputs follow the state being entered.
         pll_rst <= (state_nxt == S_PLL_RESET);
         sys_rst <= (state_nxt != S_RUN);
         fail    <= (state_nxt == S_FAILED);
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Purpose     : self-checking bench for pll_lock_supervisor (params 4/40/10/2).
// Latency     : n/a (bench).
// Backpressure: n/a (bench).
module tb_pll_lock_supervisor;

   localparam int RP = 4;
   localparam int TO = 40;
   localparam int ST = 10;
   localparam int MR = 2;
`ifdef PLL_SUP_GLITCH_FILTER_EN
   localparam int FILT = 1;
`else
   localparam int FILT = 0;
`endif
   localparam int LOSS_RUN = (FILT != 0) ? 4 : 1;

   logic       refclk = 1'b0;
   logic       rst;
   logic       locked_in;
   logic       pll_rst, sys_rst, lock_lost, fail;
   logic [7:0] relock_count;

   int n_tests = 0;
   int n_fail  = 0;

   pll_lock_supervisor #(
      .RST_PULSE_CYCLES(RP), .LOCK_TIMEOUT_CYCLES(TO),
      .STABLE_CYCLES(ST), .MAX_RETRIES(MR)
   ) dut (
      .refclk(refclk), .rst(rst), .locked_in(locked_in),
      .pll_rst(pll_rst), .sys_rst(sys_rst), .lock_lost(lock_lost),
      .relock_count(relock_count), .fail(fail)
   );

   always #5 refclk = ~refclk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge refclk);
      #1;
   endtask

   // ---------------- behavioural reference model ----------------
   // Phases and rules straight from the requirement text: time spent in a phase,
   // attempt tally, unlocked run length, and a 2-deep history of locked_in that the
   // supervisor may only trust once the PLL has been out of reset for 2 edges.
   localparam int P_RST = 0, P_WAIT = 1, P_STB = 2, P_RUN = 3, P_FAIL = 4;
   int m_phase = P_RST, m_t = 1, m_tries = 0, m_low = 0, m_relocks = 0, m_age = 0;
   bit m_lost = 0, lk_d1 = 0, lk_d2 = 0;
   logic smp_rst, smp_lk;
   bit   smp_valid = 0;

   task automatic enter(input int p);
      m_phase = p;
      m_t     = 1;
      m_low   = 0;
   endtask

   task automatic model_step(input logic r, input logic lk);
      bit ls, pll_now;
      pll_now = (m_phase == P_RST);
      ls      = (m_age >= 2) ? lk_d2 : 1'b0;
      m_lost  = 0;
      if (r) begin
         enter(P_RST);
         m_tries = 0; m_relocks = 0; m_age = 0;
      end else begin
         case (m_phase)
            P_RST:  if (m_t >= RP) enter(P_WAIT); else m_t++;
            P_WAIT: if (ls) enter(P_STB);
                    else if (m_t >= TO) begin
                       m_tries++;
                       enter((m_tries >= MR) ? P_FAIL : P_RST);
                    end else m_t++;
            P_STB:  if (!ls) enter(P_WAIT);
                    else if (m_t >= ST) begin m_tries = 0; enter(P_RUN); end
                    else m_t++;
            P_RUN: begin
               m_low = ls ? 0 : m_low + 1;
               if (m_low >= LOSS_RUN) begin
                  m_lost = 1;
                  if (m_relocks < 255) m_relocks++;
                  enter(P_RST);
               end
            end
            default: ;
         endcase
         m_age = pll_now ? 0 : m_age + 1;
      end
      lk_d2 = lk_d1;
      lk_d1 = lk;
   endtask

   always @(posedge refclk) begin
      smp_rst   <= rst;
      smp_lk    <= locked_in;
      smp_valid <= 1'b1;
   end

   always @(negedge refclk) begin
      if (smp_valid) begin
         model_step(smp_rst, smp_lk);
         check("model", {pll_rst, sys_rst, lock_lost, fail, relock_count},
               {(m_phase == P_RST), (m_phase != P_RUN), m_lost, (m_phase == P_FAIL), 8'(m_relocks)});
      end
   end

   // ---------------- directed vectors ----------------
   typedef struct {
      bit       rst;
      bit       lk;
      int       n;
      bit       pll;
      bit       sys;
      bit       fl;
      bit [7:0] cnt;
   } vec_t;

   function automatic vec_t mk(input bit r, input bit lk, input int n,
                               input bit pll, input bit sys, input bit fl);
      vec_t v;
      v.rst = r; v.lk = lk; v.n = n; v.pll = pll; v.sys = sys; v.fl = fl; v.cnt = 8'd0;
      return v;
   endfunction

   vec_t tbl[16];

   task automatic wait_sys_low(input int budget, output bit ok);
      for (int k = 0; k < budget && sys_rst !== 1'b0; k++) tick();
      ok = (sys_rst === 1'b0);
   endtask

   task automatic drop_and_watch(input int len, input int window,
                                 output int pulses, output int pll_ticks, output bit ok);
      pulses = 0; pll_ticks = 0; ok = 1;
      locked_in = 1'b0;
      for (int k = 0; k < window; k++) begin
         if (k == len) locked_in = 1'b1;
         tick();
         if (pll_rst === 1'b1) pll_ticks++;
         if (lock_lost === 1'b1) begin
            pulses++;
            if (!(pll_rst === 1'b1 && sys_rst === 1'b1)) ok = 0;
         end
      end
      locked_in = 1'b1;
   endtask

   initial begin
      int  pulses, pll_ticks, first_sys, first_pll, first_fail, lost_miss, timeouts;
      bit  ok, got;
      int  drop_len;

      rst = 1'b1;
      locked_in = 1'b0;

      // Lock never arrives: two PLL pulses then FAILED; rst recovers; then clean lock.
      tbl[0]  = mk(1, 0, 3,   1, 1, 0);   // reset state
      tbl[1]  = mk(0, 0, 3,   1, 1, 0);   // edges 1..3 after release
      tbl[2]  = mk(0, 0, 1,   0, 1, 0);   // edge 4: pll_rst falls
      tbl[3]  = mk(0, 0, 39,  0, 1, 0);   // edge 43: still waiting
      tbl[4]  = mk(0, 0, 1,   1, 1, 0);   // edge 44: second pulse
      tbl[5]  = mk(0, 0, 3,   1, 1, 0);
      tbl[6]  = mk(0, 0, 1,   0, 1, 0);   // edge 48
      tbl[7]  = mk(0, 0, 39,  0, 1, 0);   // edge 87
      tbl[8]  = mk(0, 0, 1,   0, 1, 1);   // edge 88: FAILED
      tbl[9]  = mk(0, 0, 200, 0, 1, 1);
      tbl[10] = mk(0, 1, 50,  0, 1, 1);   // lock returning does not leave FAILED
      tbl[11] = mk(1, 1, 1,   1, 1, 0);   // rst takes effect on the next edge
      tbl[12] = mk(0, 1, 3,   1, 1, 0);
      tbl[13] = mk(0, 1, 1,   0, 1, 0);   // pll_rst falls on the 4th edge
      tbl[14] = mk(0, 1, 12,  0, 1, 0);   // edge 16: sys_rst still high
      tbl[15] = mk(0, 1, 1,   0, 0, 0);   // edge 17 = 4+1+2+10: RUN

      for (int i = 0; i < 16; i++) begin
         rst       = tbl[i].rst;
         locked_in = tbl[i].lk;
         repeat (tbl[i].n) tick();
         check($sformatf("vec%0d", i), {pll_rst, sys_rst, lock_lost, fail, relock_count},
               {tbl[i].pll, tbl[i].sys, 1'b0, tbl[i].fl, tbl[i].cnt});
      end

      // One-cycle drop in RUN: lock loss unless the glitch filter is built in.
      drop_and_watch(1, 40, pulses, pll_ticks, ok);
      check("drop1_pulses", pulses, (FILT != 0) ? 0 : 1);
      check("drop1_pll_ticks", pll_ticks, (FILT != 0) ? 0 : RP);
      check("drop1_rst_at_pulse", ok, 1);
      check("drop1_relock", relock_count, (FILT != 0) ? 0 : 1);
      check("drop1_rerun", sys_rst, 0);

      // Six-cycle drop in RUN: exactly one loss in either build.
      drop_and_watch(6, 40, pulses, pll_ticks, ok);
      check("drop6_pulses", pulses, 1);
      check("drop6_rst_at_pulse", ok, 1);
      check("drop6_relock", relock_count, (FILT != 0) ? 1 : 2);
      check("drop6_rerun", sys_rst, 0);

      // Unlock at stable count 5: back to WAIT_LOCK, stable window restarts from 0.
      rst = 1'b1; locked_in = 1'b1; tick(); tick();
      rst = 1'b0;
      first_sys = 0; pll_ticks = 0;
      for (int t = 1; t <= 30; t++) begin
         if (t == 11) locked_in = 1'b0;
         if (t == 12) locked_in = 1'b1;
         tick();
         if (pll_rst === 1'b1) pll_ticks++;
         if (first_sys == 0 && sys_rst === 1'b0) first_sys = t;
      end
      check("stb_glitch_sys_fall", first_sys, 24);
      check("stb_glitch_no_new_pll", pll_ticks, RP - 1);

      // Same glitch, lock then stays away: the glitch must not have used an attempt,
      // so the first timeout re-pulses the PLL and only the second one fails.
      rst = 1'b1; locked_in = 1'b1; tick(); tick();
      rst = 1'b0;
      first_pll = 0; first_fail = 0;
      for (int t = 1; t <= 110; t++) begin
         if (t == 11) locked_in = 1'b0;
         tick();
         if (first_pll == 0 && t >= 5 && pll_rst === 1'b1) first_pll = t;
         if (first_fail == 0 && fail === 1'b1) first_fail = t;
      end
      check("stb_glitch_retry_pll", first_pll, 53);
      check("stb_glitch_retry_fail", first_fail, 97);

      // 260 lock losses: counter saturates at 255.
      rst = 1'b1; locked_in = 1'b1; tick(); tick();
      rst = 1'b0;
      drop_len  = (FILT != 0) ? 6 : 1;
      lost_miss = 0; timeouts = 0;
      for (int i = 0; i < 260; i++) begin
         wait_sys_low(60, ok);
         if (!ok) timeouts++;
         locked_in = 1'b0;
         got = 0;
         for (int k = 0; k < 20 && !got; k++) begin
            if (k == drop_len) locked_in = 1'b1;
            tick();
            if (lock_lost === 1'b1) got = 1;
         end
         locked_in = 1'b1;
         if (!got) lost_miss++;
      end
      check("sat_run_timeouts", timeouts, 0);
      check("sat_missing_pulses", lost_miss, 0);
      check("sat_relock", relock_count, 255);

      // rst in the middle of a relock sequence, then rst from RUN.
      rst = 1'b1; tick();
      check("rst_mid_seq", {pll_rst, sys_rst, lock_lost, fail, relock_count}, 12'hC00);
      rst = 1'b0;
      wait_sys_low(60, ok);
      check("reach_run", ok, 1);
      rst = 1'b1; tick();
      check("rst_in_run", {pll_rst, sys_rst, lock_lost, fail, relock_count}, 12'hC00);
      rst = 1'b0;

      // Random lock activity with occasional resets, checked against the model.
      for (int n = 0; n < 3000; ) begin
         int len;
         len = $urandom_range(1, 60);
         locked_in = ($urandom_range(0, 3) != 0);
         for (int k = 0; k < len; k++) begin
            rst = ($urandom_range(0, 399) == 0);
            tick();
            n++;
         end
      end
      rst = 1'b0;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/pll_lock_supervisor.md
PLL_LOCK_SUPERVISOR -- requirements
Module: pll_lock_supervisor

Interface
REQ-001 Parameter RST_PULSE_CYCLES, default 12, SHALL set the pll_rst pulse length in refclk cycles (1 us at 12 MHz).
REQ-002 Parameter LOCK_TIMEOUT_CYCLES, default 12000, SHALL set the maximum wait for lock per attempt (1 ms).
REQ-003 Parameter STABLE_CYCLES, default 1200, SHALL set the continuous lock time required before releasing sys_rst (100 us).
REQ-004 Parameter MAX_RETRIES, default 4, SHALL set the number of consecutive failed lock attempts before entering FAILED.
REQ-005 refclk  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  reset, synchronous, active-high.
REQ-007 locked_in  in  1  PLL locked indication; asynchronous to refclk.
REQ-008 pll_rst  out  1  reset to the PLL, active-high, registered.
REQ-009 sys_rst  out  1  reset to the downstream clock domains, active-high, registered.
REQ-010 lock_lost  out  1  one-cycle pulse on loss of lock while in RUN.
REQ-011 relock_count  out  8  number of lock losses seen in RUN; saturates at 255.
REQ-012 fail  out  1  high while in FAILED.

Function
REQ-013 locked_in SHALL pass through a two-flop synchronizer; locked_s denotes its output, delayed by 2 cycles.
REQ-014 The FSM states SHALL be PLL_RESET, WAIT_LOCK, STABLE_WAIT, RUN and FAILED; a single cycle counter is cleared on every state change.
REQ-015 PLL_RESET: pll_rst=1 and sys_rst=1; after RST_PULSE_CYCLES cycles in the state, the FSM SHALL go to WAIT_LOCK.
REQ-016 WAIT_LOCK, pll_rst=0 and sys_rst=1:
  - locked_s=1 -> STABLE_WAIT.
  - Otherwise, after LOCK_TIMEOUT_CYCLES cycles, increment retry; retry reaching MAX_RETRIES -> FAILED, else -> PLL_RESET.
REQ-017 STABLE_WAIT, sys_rst=1:
  - locked_s=0 -> WAIT_LOCK, no retry increment.
  - After STABLE_CYCLES consecutive cycles with locked_s=1 -> RUN, and retry cleared.
REQ-018 RUN, sys_rst=0 and pll_rst=0: on a lock-loss detection (REQ-026/027), in the same cycle the FSM SHALL:
  - assert lock_lost for one cycle;
  - increment relock_count, saturating;
  - assert sys_rst;
  - enter PLL_RESET.
REQ-019 FAILED: pll_rst=0, sys_rst=1, fail=1; the state SHALL be left only by rst.
REQ-020 Outputs SHALL be registered and SHALL reflect the state being entered, so they change on the same edge as the state register.
REQ-021 sys_rst SHALL never be 0 outside RUN.
REQ-022 pll_rst and lock_lost SHALL never be high in the same cycle as sys_rst=0.
REQ-023 The retry counter SHALL be wide enough for MAX_RETRIES; the cycle counter SHALL be wide enough for the largest of the three cycle parameters.

Reset
REQ-024 While rst=1, the block SHALL hold:
  - state=PLL_RESET; counter=0; retry=0; synchronizer flops=0;
  - pll_rst=1; sys_rst=1; lock_lost=0; relock_count=0; fail=0.
REQ-025 When rst deasserts, the full PLL_RESET pulse SHALL start from count 0; rst in any state, including RUN and FAILED, SHALL take effect on the next edge.

Configuration
REQ-026 With macro PLL_SUP_GLITCH_FILTER_EN defined, lock loss in RUN SHALL require locked_s=0 for 4 consecutive cycles; shorter low runs SHALL be ignored, with no pulse and no count.
REQ-027 Without PLL_SUP_GLITCH_FILTER_EN, a single cycle of locked_s=0 in RUN SHALL be a lock loss.

Verification (params 4/40/10/2 unless stated)
REQ-028 Bench: rst 3 cycles, locked_in tied 1.
  - Required: pll_rst=1 for 4 cycles.
  - Required: sys_rst falls exactly 4+1+2+10 cycles after rst release (±1 per documented registration).
  - Required: relock_count=0 throughout.
REQ-029 Bench: locked_in tied 0.
  - Required: two PLL_RESET pulses, then fail=1 and sys_rst=1 permanently.
  - Required: a later rst pulse restarts the sequence with fail=0.
REQ-030 Bench: in RUN, drop locked_in for 1 cycle, no macro.
  - Required: lock_lost pulse, relock_count=1, sys_rst=1, then a new pll_rst pulse.
  - Repeat with the macro defined: no response.
REQ-031 Bench: in RUN, drop locked_in for 6 cycles, macro defined.
  - Required: exactly one lock_lost pulse and relock_count=1.
REQ-032 Bench: in STABLE_WAIT, toggle locked_in low at count 5.
  - Required: return to WAIT_LOCK, retry unchanged, sys_rst stays 1; the next stable window restarts from 0.
REQ-033 Bench: force 260 lock losses in RUN.
  - Required: relock_count saturates at 255.
  - Required: rst mid-sequence clears all outputs to their reset values on the next edge.
